// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO between buart and the j1 IO read mux.
// Ports: clk, resetq (async low); rx_valid/rx_data/rx_rd buart handshake;
//   cpu_rd pop strobe; clr_stall clears sticky stall; head/nonempty/level/stall
//   status; rts_n (only when UART_RX_RTS_EN is defined) hysteretic flow control.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_THRESH = 12
) (
    input  logic                clk,
    input  logic                resetq,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_rd,
    input  logic                cpu_rd,
    input  logic                clr_stall,
    output logic [7:0]          head,
    output logic                nonempty,
    output logic [DEPTH_LOG2:0] level,
    output logic                stall
`ifdef UART_RX_RTS_EN
    ,
    output logic                rts_n
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = DEPTH[DEPTH_LOG2:0];

    typedef enum logic {
        IDLE,
        GUARD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign full     = (level == FULL_LVL);
    assign nonempty = (level != '0);
    assign pop      = cpu_rd & nonempty;
    // Show-ahead: CPU samples head in the same cycle it strobes cpu_rd.
    assign head     = nonempty ? mem[rd_ptr] : 8'h00;

    // GUARD gives buart one cycle to see rd and drop valid before the
    // next capture, so the same byte is never taken twice.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_valid && !full) begin
                    push    = 1'b1;
                    state_d = GUARD;
                end
            end
            GUARD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rx_rd   <= 1'b0;
            stall   <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_rd   <= push;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            // Set has priority over clear so a stall is never lost.
            if (rx_valid && full) begin
                stall <= 1'b1;
            end else if (clr_stall) begin
                stall <= 1'b0;
            end
        end
    end

    // Storage needs no reset: head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

`ifdef UART_RX_RTS_EN
    localparam int RTS_LO_I = RTS_THRESH - 4;
    localparam logic [DEPTH_LOG2:0] RTS_HI = RTS_THRESH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] RTS_LO = RTS_LO_I[DEPTH_LOG2:0];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rts_n <= 1'b0;
        end else if (level >= RTS_HI) begin
            rts_n <= 1'b1;
        end else if (level <= RTS_LO) begin
            rts_n <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors, directed corner sequences and random traffic
// against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int THR   = 12;

    logic        clk = 1'b0;
    logic        resetq = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cpu_rd = 1'b0;
    logic        clr_stall = 1'b0;
    logic        rx_rd;
    logic [7:0]  head;
    logic        nonempty;
    logic [DL:0] level;
    logic        stall;
`ifdef UART_RX_RTS_EN
    logic        rts_n;
`endif

    uart_rx_fifo #(.DEPTH_LOG2(DL), .RTS_THRESH(THR)) dut (
        .clk       (clk),
        .resetq    (resetq),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_rd     (rx_rd),
        .cpu_rd    (cpu_rd),
        .clr_stall (clr_stall),
        .head      (head),
        .nonempty  (nonempty),
        .level     (level),
        .stall     (stall)
`ifdef UART_RX_RTS_EN
        ,
        .rts_n     (rts_n)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    bit chk_en = 1'b0;

    logic [7:0] bq[$];
    logic [7:0] mq[$];
    bit m_cool  = 1'b0;
    bit m_stall = 1'b0;
    bit m_rdx   = 1'b0;
    bit m_rts   = 1'b0;

    logic [7:0] nb;
    logic [7:0] eb;

    typedef struct {
        bit         ld;
        logic [7:0] b;
        bit         rd;
        bit         clr;
        bit         e_rd;
        int         e_lvl;
        logic [7:0] e_head;
        bit         e_stall;
    } vec_t;

    vec_t tv[4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_bu();
        rx_valid = (bq.size() != 0);
        rx_data  = (bq.size() != 0) ? bq[0] : 8'h00;
    endtask

    task automatic load(input logic [7:0] b);
        bq.push_back(b);
        drive_bu();
    endtask

    task automatic compare_model();
        chk("m_level", int'(level), mq.size());
        chk("m_nonempty", int'(nonempty), int'(mq.size() != 0));
        chk("m_head", int'(head), (mq.size() != 0) ? int'(mq[0]) : 0);
        chk("m_rx_rd", int'(rx_rd), int'(m_rdx));
        chk("m_stall", int'(stall), int'(m_stall));
`ifdef UART_RX_RTS_EN
        chk("m_rts_n", int'(rts_n), int'(m_rts));
`endif
    endtask

    task automatic model_reset();
        mq.delete();
        m_cool  = 1'b0;
        m_stall = 1'b0;
        m_rdx   = 1'b0;
        m_rts   = 1'b0;
    endtask

    // One clock: inputs are set up mid-cycle, model advances from pre-edge
    // values, outputs are checked 1 time unit after the edge.
    task automatic tick(input bit rd, input bit clr);
        bit         rd_pre;
        bit         full;
        bit         cap;
        bit         pp;
        bit         v;
        logic [7:0] d;
        int         sz;
        cpu_rd    = rd;
        clr_stall = clr;
        sz     = mq.size();
        full   = (sz == DEPTH);
        v      = rx_valid;
        d      = rx_data;
        cap    = !m_cool && v && !full;
        pp     = rd && (sz > 0);
        rd_pre = rx_rd;
        @(posedge clk);
        #1;
        if (v && full) m_stall = 1'b1;
        else if (clr) m_stall = 1'b0;
        if (sz >= THR) m_rts = 1'b1;
        else if (sz <= THR - 4) m_rts = 1'b0;
        if (pp) void'(mq.pop_front());
        if (cap) mq.push_back(d);
        m_cool = cap;
        m_rdx  = cap;
        if (rd_pre && bq.size() != 0) void'(bq.pop_front());
        drive_bu();
        cpu_rd    = 1'b0;
        clr_stall = 1'b0;
        if (rx_rd) rd_cnt++;
        if (chk_en) compare_model();
    endtask

    task automatic drain();
        for (int n = 0; n < 80 && (mq.size() != 0 || bq.size() != 0); n++) begin
            tick(1'b1, 1'b0);
        end
        tick(1'b0, 1'b0);
        chk("drain_level", int'(level), 0);
    endtask

    initial begin
        tv[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1, 8'h41, 1'b0};
        tv[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 8'h41, 1'b0};
        tv[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
        tv[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};

        #1 resetq = 1'b0;
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_nonempty", int'(nonempty), 0);
        chk("rst_head", int'(head), 0);
        chk("rst_rx_rd", int'(rx_rd), 0);
        chk("rst_stall", int'(stall), 0);
`ifdef UART_RX_RTS_EN
        chk("rst_rts_n", int'(rts_n), 0);
`endif
        @(posedge clk);
        #1 resetq = 1'b1;
        model_reset();
        chk_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            if (tv[i].ld) load(tv[i].b);
            tick(tv[i].rd, tv[i].clr);
            chk("tv_rx_rd", int'(rx_rd), int'(tv[i].e_rd));
            chk("tv_level", int'(level), tv[i].e_lvl);
            chk("tv_head", int'(head), int'(tv[i].e_head));
            chk("tv_stall", int'(stall), int'(tv[i].e_stall));
        end

        rd_cnt = 0;
        for (int i = 0; i < 17; i++) load(8'(i));
        for (int n = 0; n < 60 && bq.size() != 1; n++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("burst_level", int'(level), 16);
        chk("burst_rd_pulses", rd_cnt, 16);
        chk("burst_stall", int'(stall), 1);
        chk("burst_held", bq.size(), 1);
        tick(1'b0, 1'b1);
        chk("stall_set_wins", int'(stall), 1);
        for (int i = 0; i < 17; i++) begin
            chk("burst_order", int'(head), i);
            tick(1'b1, 1'b0);
        end
        tick(1'b0, 1'b0);
        chk("burst_empty", int'(level), 0);
        chk("stall_hold", int'(stall), 1);
        tick(1'b0, 1'b1);
        chk("stall_clr", int'(stall), 0);

        nb = 8'h80;
        eb = 8'h80;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 10; i++) begin
                load(nb);
                nb = nb + 8'd1;
            end
            for (int n = 0; n < 40 && bq.size() != 0; n++) tick(1'b0, 1'b0);
            chk("wrap_level", int'(level), 10);
            for (int i = 0; i < 10; i++) begin
                chk("wrap_order", int'(head), int'(eb));
                eb = eb + 8'd1;
                tick(1'b1, 1'b0);
            end
        end
        chk("wrap_empty", int'(level), 0);

        for (int i = 0; i < 5; i++) load(8'hC0 + 8'(i));
        for (int n = 0; n < 30 && bq.size() != 0; n++) tick(1'b0, 1'b0);
        chk("sim_pre_level", int'(level), 5);
        load(8'hA5);
        chk("sim_head0", int'(head), 'hC0);
        tick(1'b1, 1'b0);
        chk("sim_level", int'(level), 5);
        chk("sim_head1", int'(head), 'hC1);
        drain();

        tick(1'b1, 1'b0);
        chk("empty_pop_level", int'(level), 0);
        chk("empty_pop_head", int'(head), 0);

        for (int c = 0; c < 3000; c++) begin
            bit rd;
            if ($urandom_range(0, 2) == 0 && bq.size() < 4) load(8'($urandom));
            if (c < 1500) rd = ($urandom_range(0, 5) == 0);
            else rd = ($urandom_range(0, 1) == 0);
            tick(rd, $urandom_range(0, 15) == 0);
        end
        drain();

        for (int i = 0; i < 12; i++) load(8'h20 + 8'(i));
        for (int n = 0; n < 40 && level != 7; n++) tick(1'b0, 1'b0);
        chk("pre_rst_level", int'(level), 7);
        chk("pre_rst_rx_rd", int'(rx_rd), 1);
        #2 resetq = 1'b0;
        #1;
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_nonempty", int'(nonempty), 0);
        chk("mid_rst_rx_rd", int'(rx_rd), 0);
        chk("mid_rst_head", int'(head), 0);
        model_reset();
        #1 resetq = 1'b1;
        tick(1'b0, 1'b0);
        chk("recapture_head", int'(head), 'h26);
        drain();

`ifdef UART_RX_RTS_EN
        for (int i = 0; i < 12; i++) load(8'h60 + 8'(i));
        for (int n = 0; n < 40 && bq.size() != 0; n++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rts_at12", int'(rts_n), 1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("rts_at9_level", int'(level), 9);
        chk("rts_at9", int'(rts_n), 1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("rts_at8", int'(rts_n), 0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
